// File: rtl/guarded_fsm_pkg.sv
// Shared types and opcode constants for the guarded input-forwarding FSM.
package guarded_fsm_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CMD_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_PASS = 3'd2,
    ST_HOLD = 3'd3,
    ST_LOCK = 3'd4
  } state_t;

  localparam logic [CMD_W-1:0] OP_NOP         = 3'd0;
  localparam logic [CMD_W-1:0] OP_ARM         = 3'd1;
  localparam logic [CMD_W-1:0] OP_GO          = 3'd2;
  localparam logic [CMD_W-1:0] OP_PAUSE       = 3'd3;
  localparam logic [CMD_W-1:0] OP_STOP        = 3'd4;
  localparam logic [CMD_W-1:0] OP_ILLEGAL_MIN = 3'd5;

  // Opcodes 5-7 are undefined and count as protocol violations.
  function automatic logic is_illegal_op(input logic [CMD_W-1:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/fsm_timeout_counter.sv
// Cycle counter for the ARM window: clears when idle, counts while enabled,
// and flags the final allowed cycle.
module fsm_timeout_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_q;

  assign expire_c = (count_q == CNT_W'(TIMEOUT - 1));

  // Holds at the terminal value; the owning FSM leaves ARM on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expire_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/guarded_input_fsm.sv
// Command-driven mode FSM gating data_in to a registered output; illegal
// commands, corrupted state codes and violation overflow force a sticky LOCK.
module guarded_input_fsm
  import guarded_fsm_pkg::*;
#(
  parameter int unsigned DATA_W   = 3,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned MAX_VIOL = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CMD_W-1:0]   cmd,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  out,
  output logic               out_valid,
  output logic [STATE_W-1:0] state_o,
  output logic               err
);

  localparam int unsigned VIOL_W = $clog2(MAX_VIOL + 1);

  state_t            state_q, state_d;
  logic [VIOL_W-1:0] viol_q, viol_d;
  logic [DATA_W-1:0] out_d;
  logic              out_valid_d;
  logic              err_d;
  logic              accept_c;
  logic              illegal_c;
  logic              expire_c;

  assign cmd_ready = (state_q != ST_LOCK);
  assign accept_c  = cmd_valid && cmd_ready;
  assign illegal_c = accept_c && is_illegal_op(cmd);
  assign state_o   = state_q;

  fsm_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_q != ST_ARM),
    .enable   (state_q == ST_ARM),
    .expire_c (expire_c)
  );

  // Next state, violation count and next output values.
  always_comb begin
    state_d     = state_q;
    viol_d      = viol_q;
    out_d       = out;
    out_valid_d = 1'b0;
    err_d       = err;

    case (state_q)
      ST_IDLE: begin
        if (accept_c && cmd == OP_ARM) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (accept_c && cmd == OP_GO)        state_d = ST_PASS;
        else if (accept_c && cmd == OP_STOP) state_d = ST_IDLE;
        else if (expire_c)                   state_d = ST_IDLE;
      end
      ST_PASS: begin
        if (accept_c && cmd == OP_PAUSE)     state_d = ST_HOLD;
        else if (accept_c && cmd == OP_STOP) state_d = ST_IDLE;
      end
      ST_HOLD: begin
        if (accept_c && cmd == OP_GO)        state_d = ST_PASS;
        else if (accept_c && cmd == OP_STOP) state_d = ST_IDLE;
      end
      ST_LOCK: state_d = ST_LOCK;
      default: state_d = ST_LOCK;
    endcase

    // A violation overflow overrides whatever the command decode chose.
    if (illegal_c) begin
      if (viol_q != VIOL_W'(MAX_VIOL)) viol_d = viol_q + VIOL_W'(1);
      if (viol_q >= VIOL_W'(MAX_VIOL - 1)) state_d = ST_LOCK;
    end

    if (state_d == ST_IDLE || state_d == ST_LOCK) begin
      out_d = '0;
    end else if (state_q == ST_PASS && state_d == ST_PASS) begin
      out_d       = data_in;
      out_valid_d = 1'b1;
    end else if (state_q != ST_PASS && state_q != ST_HOLD) begin
      out_d = '0;
    end

    if (state_d == ST_LOCK) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      viol_q    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      viol_q    <= viol_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      err       <= err_d;
    end
  end

endmodule
